// File: rtl/newhope_pkg.sv
// Shared constants and FSM encoding for the CPA encryption pipeline stages.
package newhope_pkg;

  localparam int unsigned N         = 512;
  localparam int unsigned Q         = 12289;
  localparam int unsigned BARRETT_M = 21843;
  localparam int unsigned BARRETT_K = 28;
  localparam int unsigned DW        = 16;
  localparam int unsigned AW        = 9;

  localparam int unsigned PW = 28;  // product a*t
  localparam int unsigned MW = 43;  // product * BARRETT_M
  localparam int unsigned RW = 15;  // Barrett remainder, [0,2Q)

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } stage_state_e;

endpackage

// File: rtl/barrett_reduce_pl.sv
// Two-cycle pipelined (a*b) mod-Q partial reduction; output lies in [0,2Q).
module barrett_reduce_pl
  import newhope_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          vld_in,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          vld_out,
  output logic          busy,
  output logic [RW-1:0] r
);

  logic          vld_p2_q, vld_p2_d;
  logic          vld_p3_q, vld_p3_d;
  logic [PW-1:0] prod_p2_q, prod_p2_d;
  logic [RW-1:0] r_p3_q, r_p3_d;
  logic [MW-1:0] pm;
  logic [RW-1:0] qh;
  logic [PW-1:0] qq;

  always_comb begin
    vld_p2_d  = vld_p2_q;
    vld_p3_d  = vld_p3_q;
    prod_p2_d = prod_p2_q;
    r_p3_d    = r_p3_q;
    pm        = MW'(prod_p2_q) * MW'(BARRETT_M);
    qh        = RW'(pm >> BARRETT_K);
    qq        = PW'(qh) * PW'(Q);
    if (en) begin
      // P2: full-width product of the operands straight off the BRAM ports
      prod_p2_d = PW'(a) * PW'(b);
      vld_p2_d  = vld_in;
      // P3: quotient estimate is low by at most 1, so the remainder fits in RW bits
      r_p3_d    = RW'(prod_p2_q - qq);
      vld_p3_d  = vld_p2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else begin
      vld_p2_q <= vld_p2_d;
      vld_p3_q <= vld_p3_d;
    end
    prod_p2_q <= prod_p2_d;
    r_p3_q    <= r_p3_d;
  end

  assign vld_out = vld_p3_q;
  assign busy    = vld_p2_q | vld_p3_q;
  assign r       = r_p3_q;

endmodule

// File: rtl/pl_pointwise_mac.sv
// Stage-1 pointwise U[i] = (A[i]*T[i] + E[i]) mod Q over N coefficients, one per cycle.
module pl_pointwise_mac
  import newhope_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start_stage,
  output logic          done_stage,
  output logic [AW-1:0] addr_rd,
  input  logic [DW-1:0] din_a,
  input  logic [DW-1:0] din_t,
  input  logic [DW-1:0] din_e,
  output logic          we_u,
  output logic [AW-1:0] addr_u,
  output logic [DW-1:0] dout_u
);

  stage_state_e  state_q, state_d;
  logic [AW-1:0] addr_rd_q, addr_rd_d;
  logic          vld_p0_q, vld_p0_d;
  logic          vld_p1_q, vld_p1_d;
  logic [AW-1:0] idx_p1_q, idx_p1_d;
  logic [AW-1:0] idx_p2_q, idx_p2_d;
  logic [AW-1:0] idx_p3_q, idx_p3_d;
  logic [DW-1:0] e_p2_q, e_p2_d;
  logic [DW-1:0] e_p3_q, e_p3_d;
  logic          we_u_q, we_u_d;
  logic [AW-1:0] addr_u_q, addr_u_d;
  logic [DW-1:0] dout_u_q, dout_u_d;
  logic          done_q, done_d;
  logic          vld_p3;
  logic          mac_busy;
  logic [RW-1:0] r_p3;

  // r + e is below 3Q for in-range operands, so two folds land in [0,Q)
  function automatic logic [DW-1:0] mod_fold(input logic [DW-1:0] s);
    logic [DW-1:0] t;
    t = (s >= DW'(Q)) ? s - DW'(Q) : s;
    return (t >= DW'(Q)) ? t - DW'(Q) : t;
  endfunction

  barrett_reduce_pl u_barrett (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .vld_in  (vld_p1_q),
    .a       (din_a),
    .b       (din_t),
    .vld_out (vld_p3),
    .busy    (mac_busy),
    .r       (r_p3)
  );

  always_comb begin
    state_d   = state_q;
    addr_rd_d = addr_rd_q;
    vld_p0_d  = vld_p0_q;
    vld_p1_d  = vld_p1_q;
    idx_p1_d  = idx_p1_q;
    idx_p2_d  = idx_p2_q;
    idx_p3_d  = idx_p3_q;
    e_p2_d    = e_p2_q;
    e_p3_d    = e_p3_q;
    we_u_d    = we_u_q;
    addr_u_d  = addr_u_q;
    dout_u_d  = dout_u_q;
    done_d    = done_q;
    if (en) begin
      vld_p0_d = 1'b0;
      done_d   = 1'b0;
      // P0: address issue
      case (state_q)
        ST_IDLE: begin
          if (start_stage) begin
            state_d   = ST_RUN;
            addr_rd_d = '0;
            vld_p0_d  = 1'b1;
          end
        end
        ST_RUN: begin
          if (addr_rd_q == AW'(N - 1)) begin
            state_d = ST_DRAIN;
          end else begin
            addr_rd_d = addr_rd_q + AW'(1);
            vld_p0_d  = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!(vld_p0_q || vld_p1_q || mac_busy)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
      // P1: BRAM data for idx_p1 is on din_* this cycle
      vld_p1_d = vld_p0_q;
      idx_p1_d = addr_rd_q;
      // P2/P3: e and index ride alongside the Barrett pipe
      e_p2_d   = din_e;
      idx_p2_d = idx_p1_q;
      e_p3_d   = e_p2_q;
      idx_p3_d = idx_p2_q;
      // P4: final add, fold and output register
      we_u_d   = vld_p3;
      if (vld_p3) begin
        addr_u_d = idx_p3_q;
        dout_u_d = mod_fold({1'b0, r_p3} + e_p3_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_rd_q <= '0;
      vld_p0_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
      we_u_q    <= 1'b0;
      addr_u_q  <= '0;
      dout_u_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_rd_q <= addr_rd_d;
      vld_p0_q  <= vld_p0_d;
      vld_p1_q  <= vld_p1_d;
      we_u_q    <= we_u_d;
      addr_u_q  <= addr_u_d;
      dout_u_q  <= dout_u_d;
      done_q    <= done_d;
    end
    idx_p1_q <= idx_p1_d;
    idx_p2_q <= idx_p2_d;
    idx_p3_q <= idx_p3_d;
    e_p2_q   <= e_p2_d;
    e_p3_q   <= e_p3_d;
  end

  // A stalled block must not be seen writing or completing
  assign we_u       = we_u_q & en;
  assign done_stage = done_q & en;
  assign addr_rd    = addr_rd_q;
  assign addr_u     = addr_u_q;
  assign dout_u     = dout_u_q;

endmodule

// File: tb/tb_pl_pointwise_mac.sv
// Self-checking bench for pl_pointwise_mac: BRAM model, golden (a*t+e)%Q scoreboard, timing checks.
module tb_pl_pointwise_mac;

  localparam int NN = 512;
  localparam int QQ = 12289;

  logic        clk = 1'b0;
  logic        rst, en, start_stage;
  logic        done_stage, we_u;
  logic [8:0]  addr_rd, addr_u;
  logic [15:0] din_a, din_t, din_e, dout_u;

  always #5 clk = ~clk;

  pl_pointwise_mac dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .start_stage (start_stage),
    .done_stage  (done_stage),
    .addr_rd     (addr_rd),
    .din_a       (din_a),
    .din_t       (din_t),
    .din_e       (din_e),
    .we_u        (we_u),
    .addr_u      (addr_u),
    .dout_u      (dout_u)
  );

  // Operand BRAMs: one-cycle read latency, read port enabled by the global enable
  logic [15:0] mem_a [NN];
  logic [15:0] mem_t [NN];
  logic [15:0] mem_e [NN];
  always @(posedge clk) begin
    if (en) begin
      din_a <= mem_a[addr_rd];
      din_t <= mem_t[addr_rd];
      din_e <= mem_e[addr_rd];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int pass_wr, gap, done_cnt, done_cyc, first_wr_cyc;
  bit quiet;
  logic [15:0] got  [NN];
  logic [15:0] got3 [NN];

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic int golden(input int i);
    return (int'(mem_a[i]) * int'(mem_t[i]) + int'(mem_e[i])) % QQ;
  endfunction

  // Scoreboard: i-th write of a pass must carry address i and golden(i), back to back
  always @(negedge clk) begin
    if (!en) chk("we_u_while_stalled", we_u, 0);
    if (quiet) begin
      chk("quiet_we_u", we_u, 0);
      chk("quiet_done", done_stage, 0);
    end else begin
      if (done_stage) begin
        done_cnt++;
        if (done_cnt == 1) done_cyc = cyc;
      end
      if (we_u) begin
        if (pass_wr >= NN) begin
          chk("extra_write", pass_wr, NN - 1);
        end else begin
          chk("addr_u", addr_u, pass_wr);
          chk("dout_u", dout_u, golden(pass_wr));
          if (pass_wr > 0) chk("write_gap", gap, 0);
          else first_wr_cyc = cyc;
          got[pass_wr] = dout_u;
        end
        pass_wr++;
        gap = 0;
      end else if (en && pass_wr > 0) begin
        gap++;
      end
    end
  end

  // Offsets are relative to the start cycle c; -1 disables an event.
  // s1/s2: first cycle of a 3-cycle en=0 window.
  task automatic run_pass(input string nm, input int exp_done, input int s1, input int s2,
                          input int rst_at, input int rs1, input int rs2, input int exp_writes);
    int c;
    int off;
    @(posedge clk); #1;
    pass_wr = 0; gap = 0; done_cnt = 0; done_cyc = -1; first_wr_cyc = -1; quiet = 0;
    start_stage = 1'b1;
    c = cyc;
    for (int k = 1; k <= 560; k++) begin
      @(posedge clk); #1;
      off = cyc - c;
      en = !((s1 >= 0 && off >= s1 && off < s1 + 3) || (s2 >= 0 && off >= s2 && off < s2 + 3));
      rst = (rst_at >= 0 && off == rst_at);
      start_stage = (off == rs1) || (off == rs2);
      if ((rst_at >= 0 && off == rst_at + 1) || (rst_at < 0 && off == exp_done + 1)) quiet = 1;
    end
    start_stage = 1'b0; en = 1'b1; rst = 1'b0; quiet = 1;
    chk({nm, "_write_count"}, pass_wr, exp_writes);
    if (rst_at < 0) begin
      chk({nm, "_done_cycle"}, done_cyc, c + exp_done);
      chk({nm, "_done_count"}, done_cnt, 1);
      chk({nm, "_first_write_cycle"}, first_wr_cyc, c + 5);
    end else begin
      chk({nm, "_done_count"}, done_cnt, 0);
    end
  endtask

  int unsigned seed_v;
  int mism;

  initial begin
    rst = 1'b1; en = 1'b1; start_stage = 1'b0; quiet = 1;
    pass_wr = 0; gap = 0; done_cnt = 0; done_cyc = -1; first_wr_cyc = -1;
    for (int i = 0; i < NN; i++) begin
      mem_a[i] = 16'd0; mem_t[i] = 16'd0; mem_e[i] = 16'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_done_stage", done_stage, 0);
    chk("reset_we_u", we_u, 0);
    chk("reset_addr_u", addr_u, 0);
    chk("reset_dout_u", dout_u, 0);
    chk("reset_addr_rd", addr_rd, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Test 1: A=T=1, E=0
    for (int i = 0; i < NN; i++) begin
      mem_a[i] = 16'd1; mem_t[i] = 16'd1; mem_e[i] = 16'd0;
    end
    run_pass("t1", 517, -1, -1, -1, -1, -1, NN);
    chk("t1_u0_literal", got[0], 1);
    chk("t1_u511_literal", got[511], 1);

    // Test 2: boundary operand triples cycled over the polynomial
    for (int i = 0; i < NN; i++) begin
      case (i % 3)
        0: begin mem_a[i] = 16'(QQ - 1); mem_t[i] = 16'(QQ - 1); mem_e[i] = 16'(QQ - 1); end
        1: begin mem_a[i] = 16'd2; mem_t[i] = 16'd6145; mem_e[i] = 16'd0; end
        default: begin mem_a[i] = 16'd0; mem_t[i] = 16'($urandom_range(QQ - 1, 0)); mem_e[i] = 16'd12288; end
      endcase
    end
    run_pass("t2", 517, -1, -1, -1, -1, -1, NN);
    chk("t2_qm1_literal", got[0], 0);
    chk("t2_2x6145_literal", got[1], 1);
    chk("t2_e_only_literal", got[2], 12288);
    chk("t2_u510_literal", got[510], 0);

    // Test 3: seeded random operands in [0,Q)
    seed_v = $urandom(32'd20240611);
    for (int i = 0; i < NN; i++) begin
      mem_a[i] = 16'($urandom_range(QQ - 1, 0));
      mem_t[i] = 16'($urandom_range(QQ - 1, 0));
      mem_e[i] = 16'($urandom_range(QQ - 1, 0));
    end
    run_pass("t3", 517, -1, -1, -1, -1, -1, NN);
    for (int i = 0; i < NN; i++) got3[i] = got[i];

    // Test 4: two 3-cycle stalls, at the write of i=100 and of i=511
    run_pass("t4", 523, 105, 519, -1, -1, -1, NN);
    mism = 0;
    for (int i = 0; i < NN; i++) if (got[i] !== got3[i]) mism++;
    chk("t4_equals_t3", mism, 0);

    // Test 5: reset mid-pass, then a clean pass
    run_pass("t5_abort", 9999, -1, -1, 200, -1, -1, 196);
    run_pass("t5_rerun", 517, -1, -1, -1, -1, -1, NN);
    mism = 0;
    for (int i = 0; i < NN; i++) if (got[i] !== got3[i]) mism++;
    chk("t5_equals_t3", mism, 0);

    // Test 6: start repeated mid-run and in the DONE cycle
    run_pass("t6", 517, -1, -1, -1, 50, 517, NN);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
